// File: rtl/itr_ctrl_pkg.sv
// rtl/itr_ctrl_pkg.sv - shared FSM encoding and permutation-select helpers for the transform input controller
package itr_ctrl_pkg;

  localparam int PERM_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  // Lane rotation advances one step per column and one per pass, wrapping at 16 lanes.
  function automatic logic [PERM_W-1:0] perm_sel(input logic [3:0] col, input logic [2:0] pass);
    return col + {1'b0, pass};
  endfunction

endpackage

// File: rtl/itr_ctrl_if.sv
// rtl/itr_ctrl_if.sv - control/status bundle between the transform sequencer and its host
interface itr_ctrl_if;
  import itr_ctrl_pkg::*;

  logic              START;
  logic              STALL;
  logic              SEL_ITR;
  logic [PERM_W-1:0] SEL_PERMR;
  logic              VALID;
  logic [2:0]        PASS;
  logic [3:0]        COL;
  logic              BUSY;
  logic              DONE;

  modport master (
    output START, STALL,
    input  SEL_ITR, SEL_PERMR, VALID, PASS, COL, BUSY, DONE
  );

  modport slave (
    input  START, STALL,
    output SEL_ITR, SEL_PERMR, VALID, PASS, COL, BUSY, DONE
  );
endinterface

// File: rtl/itr_ctrl.sv
// rtl/itr_ctrl.sv - multi-pass column sequencer driving input-interface source select and lane rotation
module itr_ctrl
  import itr_ctrl_pkg::*;
#(
  parameter int N_COL   = 16,
  parameter int N_PASS  = 3,
  parameter int GAP_CYC = 2
) (
  input  logic      CLK,
  input  logic      RSTn,
  itr_ctrl_if.slave bus
);

  localparam logic [3:0] COL_LAST  = 4'(N_COL - 1);
  localparam logic [2:0] PASS_LAST = 3'(N_PASS - 1);
  localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYC - 1);

  logic [1:0] state;
  logic [3:0] gap_cnt;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state         <= ST_IDLE;
      gap_cnt       <= '0;
      bus.SEL_ITR   <= 1'b0;
      bus.SEL_PERMR <= '0;
      bus.VALID     <= 1'b0;
      bus.PASS      <= '0;
      bus.COL       <= '0;
      bus.BUSY      <= 1'b0;
      bus.DONE      <= 1'b0;
    end else begin
      bus.VALID <= 1'b0;
      bus.DONE  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.START) begin
            state         <= ST_RUN;
            bus.BUSY      <= 1'b1;
            bus.VALID     <= 1'b1;
            bus.PASS      <= '0;
            bus.COL       <= '0;
            bus.SEL_ITR   <= 1'b0;
            bus.SEL_PERMR <= '0;
          end
        end
        ST_RUN: begin
          // A stall only suppresses VALID; position and selects stay frozen.
          if (!bus.STALL) begin
            if (bus.COL == COL_LAST) begin
              if (bus.PASS == PASS_LAST) begin
                state    <= ST_FIN;
                bus.DONE <= 1'b1;
              end else begin
                state   <= ST_GAP;
                gap_cnt <= GAP_LOAD;
              end
            end else begin
              bus.COL       <= bus.COL + 4'd1;
              bus.VALID     <= 1'b1;
              bus.SEL_PERMR <= perm_sel(bus.COL + 4'd1, bus.PASS);
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == 4'd0) begin
            state         <= ST_RUN;
            bus.VALID     <= 1'b1;
            bus.PASS      <= bus.PASS + 3'd1;
            bus.COL       <= '0;
            bus.SEL_ITR   <= 1'b1;
            bus.SEL_PERMR <= perm_sel(4'd0, bus.PASS + 3'd1);
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          bus.BUSY <= 1'b0;
          bus.PASS <= '0;
          bus.COL  <= '0;
        end
      endcase
    end
  end

endmodule
